// File: rtl/gb_bus_pkg.sv
// Shared constants and types for the LR35902 bus arbiter and its OAM DMA engine.
package gb_bus_pkg;

  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam logic [15:0] OAM_BASE     = 16'hFE00;
  localparam logic [7:0]  DMA_LEN      = 8'd160;
  localparam logic [15:0] HRAM_LO      = 16'hFF80;
  localparam logic [15:0] HRAM_HI      = 16'hFFFE;
  localparam logic [7:0]  ECHO_FOLD    = 8'hE0;

  typedef enum logic [1:0] {IDLE, START, READ, WRITE} dma_state_t;

  // Source pages 0xE0-0xFF alias work RAM (echo region), so fold them down by 0x20.
  function automatic logic [7:0] fold_src(input logic [7:0] page);
    return (page >= ECHO_FOLD) ? (page - 8'h20) : page;
  endfunction

endpackage

// File: rtl/gb_bus_if.sv
// CPU-side and memory-side bus signals of the arbiter, plus the DMA state for observation.
// Strobe semantics: cpu_load/cpu_store and mem_load/mem_store are single-cycle requests
// that complete in the cycle they are raised; read data is valid in that same cycle.
interface gb_bus_if;
  import gb_bus_pkg::*;

  logic [15:0] cpu_address;
  logic        cpu_load;
  logic        cpu_store;
  logic [7:0]  cpu_outdata;
  logic [7:0]  cpu_indata;
  logic [15:0] mem_address;
  logic        mem_load;
  logic        mem_store;
  logic [7:0]  mem_outdata;
  logic [7:0]  mem_indata;
  logic        dma_active;
  dma_state_t  dbg_state;

  // Arbiter side.
  modport slave (
    input  cpu_address, cpu_load, cpu_store, cpu_outdata, mem_indata,
    output cpu_indata, mem_address, mem_load, mem_store, mem_outdata, dma_active, dbg_state
  );

  // CPU + memory environment side.
  modport master (
    output cpu_address, cpu_load, cpu_store, cpu_outdata, mem_indata,
    input  cpu_indata, mem_address, mem_load, mem_store, mem_outdata, dma_active, dbg_state
  );

endinterface

// File: rtl/gb_oam_dma.sv
// OAM DMA engine: copies 160 bytes from {src, 00} to 0xFE00 as READ/WRITE pairs.
// A stalled cycle holds state, index and buffer so the same bus cycle is retried.
module gb_oam_dma
  import gb_bus_pkg::*;
(
  input  logic        clock4,
  input  logic        resetn,
  input  logic        start,
  input  logic [7:0]  start_src,
  input  logic        stall,
  input  logic [7:0]  mem_indata,
  output dma_state_t  state,
  output logic        active,
  output logic        busy,
  output logic [7:0]  src,
  output logic [15:0] dma_address,
  output logic        dma_load,
  output logic        dma_store,
  output logic [7:0]  dma_outdata
);

  dma_state_t state_q, state_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] buf_q, buf_d;
  logic [7:0] src_q, src_d;

  // State, index, buffer and source registers.
  always_ff @(posedge clock4 or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      idx_q   <= 8'h00;
      buf_q   <= 8'h00;
      src_q   <= 8'hFF;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      src_q   <= src_d;
    end
  end

  // Next-state logic; a register write restarts the copy from any state.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    src_d   = src_q;
    case (state_q)
      START: state_d = READ;
      READ: begin
        if (!stall) begin
          buf_d   = mem_indata;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (!stall) begin
          if (idx_q == DMA_LEN - 8'd1) begin
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = READ;
          end
        end
      end
      default: state_d = state_q;
    endcase
    if (start) begin
      src_d   = start_src;
      idx_d   = 8'h00;
      state_d = START;
    end
  end

  // Bus request the engine would issue if granted this cycle.
  always_comb begin
    dma_address = OAM_BASE + {8'h00, idx_q};
    dma_load    = 1'b0;
    dma_store   = 1'b0;
    dma_outdata = buf_q;
    if (state_q == READ) begin
      dma_address = {fold_src(src_q), idx_q};
      dma_load    = 1'b1;
    end else if (state_q == WRITE) begin
      dma_store = 1'b1;
    end
  end

  assign state  = state_q;
  assign active = (state_q != IDLE);
  assign busy   = (state_q == READ) || (state_q == WRITE);
  assign src    = src_q;

endmodule

// File: rtl/gb_bus_arbiter.sv
// Shares the external bus between the CPU and the OAM DMA engine.
// Build option GB_DMA_BUS_LOCK_EN: when defined, the CPU is locked out of every
// non-HRAM address during a copy; when undefined, the CPU always wins and the DMA waits.
module gb_bus_arbiter
  import gb_bus_pkg::*;
(
  input logic     clock4,
  input logic     resetn,
  gb_bus_if.slave bus
);

  logic        reg_hit;
  logic        reg_store;
  logic        reg_load;
  logic        cpu_req;
  logic        stall;
  logic        cpu_blocked;
  logic        dma_grant;
  logic        dma_active;
  logic        dma_busy;
  dma_state_t  dma_state;
  logic [7:0]  dma_src;
  logic [15:0] dma_address;
  logic        dma_load;
  logic        dma_store;
  logic [7:0]  dma_outdata;

  // A store to the DMA register wins the decode when load and store are both raised.
  assign reg_hit   = (bus.cpu_address == DMA_REG_ADDR);
  assign reg_store = bus.cpu_store && reg_hit;
  assign reg_load  = bus.cpu_load && !bus.cpu_store && reg_hit;
  assign cpu_req   = bus.cpu_load || bus.cpu_store;

`ifdef GB_DMA_BUS_LOCK_EN
  logic hram_hit;
  assign hram_hit    = (bus.cpu_address >= HRAM_LO) && (bus.cpu_address <= HRAM_HI);
  assign stall       = cpu_req && hram_hit;
  assign cpu_blocked = dma_active && !hram_hit;
`else
  assign stall       = cpu_req;
  assign cpu_blocked = 1'b0;
`endif

  assign dma_grant = dma_busy && !stall;

  gb_oam_dma u_dma (
    .clock4      (clock4),
    .resetn      (resetn),
    .start       (reg_store),
    .start_src   (bus.cpu_outdata),
    .stall       (stall),
    .mem_indata  (bus.mem_indata),
    .state       (dma_state),
    .active      (dma_active),
    .busy        (dma_busy),
    .src         (dma_src),
    .dma_address (dma_address),
    .dma_load    (dma_load),
    .dma_store   (dma_store),
    .dma_outdata (dma_outdata)
  );

  // Grant mux: CPU passthrough by default, lockout response, then DMA ownership.
  always_comb begin
    bus.mem_address = bus.cpu_address;
    bus.mem_load    = bus.cpu_load && !reg_load;
    bus.mem_store   = bus.cpu_store && !reg_store;
    bus.mem_outdata = bus.cpu_outdata;
    bus.cpu_indata  = reg_load ? dma_src : bus.mem_indata;
    if (cpu_blocked) begin
      bus.mem_load   = 1'b0;
      bus.mem_store  = 1'b0;
      bus.cpu_indata = 8'hFF;
    end
    if (dma_grant) begin
      bus.mem_address = dma_address;
      bus.mem_load    = dma_load;
      bus.mem_store   = dma_store;
      bus.mem_outdata = dma_outdata;
    end
  end

  assign bus.dma_active = dma_active;
  assign bus.dbg_state  = dma_state;

endmodule
